// File: rtl/mips_inst_encoder.sv
`timescale 1ns/1ps
// mips_inst_encoder: encodes field-level addu/addiu/sw requests into 32-bit MIPS words and writes them sequentially into instruction memory.
// Latency: 1 cycle from request acceptance to imem_we carrying the encoded word.
// Backpressure: one-entry output register; in_ready = !imem_we || imem_ready, so a stalled write blocks new requests.
module mips_inst_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_err;
    logic                  r_full;
    logic [ADDR_WIDTH:0]   r_count;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_at_top;
    logic                  w_full_eff;
    logic                  w_op_ok;
    logic                  w_gen;
    logic                  w_drop;
    logic                  w_we_nxt;
    logic                  w_start;
    logic [31:0]           w_enc;

    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = r_we && imem_ready;
    assign w_at_top   = (r_addr == {ADDR_WIDTH{1'b1}});
    // A write retiring into the last word fills memory in the same cycle, so
    // a request accepted alongside it must already be treated as overflow.
    assign w_full_eff = r_full || (w_complete && w_at_top);
    assign w_op_ok    = (in_op != 2'd3);
    assign w_gen      = w_accept && w_op_ok && !w_full_eff;
    assign w_drop     = w_accept && !(w_op_ok && !w_full_eff);
    // Output register is occupied next cycle if a new word enters or the current one is still stalled.
    assign w_we_nxt   = w_gen || (r_we && !imem_ready);
    assign w_start    = (r_state == S_IDLE) && start;

    // Field-to-word encoding for the ops the decode stage understands.
    always_comb begin
        w_enc = 32'd0;
        case (in_op)
            2'd0:    w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            2'd1:    w_enc = {6'b001001, in_rs, in_rt, in_imm};
            2'd2:    w_enc = {6'b101011, in_rs, in_rt, in_imm};
            default: w_enc = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a last request goes through DRAIN only if a write is still outstanding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_accept && in_last) w_state_nxt = w_we_nxt ? S_DRAIN : S_DONE;
            S_DRAIN: if (w_complete) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_in_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = !r_we || imem_ready;
                busy       = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Write register, address pointer, word count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_count <= '0;
        end else if (w_start) begin
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_count <= '0;
        end else begin
            r_we <= w_we_nxt;
            if (w_complete) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
                if (w_at_top) begin
                    r_full <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_gen) begin
                r_wdata <= w_enc;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign count      = r_count;

endmodule
